// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - direct-mapped write-through no-write-allocate single-word cache controller
//
// Purpose: accepts one CPU load/store at a time, serves load hits from a
// direct-mapped line store, forwards load misses and every store to a
// word-addressed main memory, and keeps saturating load hit/miss counters.
//
// Ports:
//   clk, rst                    clock (rising edge), asynchronous active-low reset
//   cpuReq*                     CPU request: valid/ready handshake, byte address,
//                               store data, write enable (1 = store)
//   cpuRespValid/DataOut        one-cycle completion pulse with load (or store) data
//   memReq*                     memory request held stable until memRespValid is sampled
//   memRespValid/DataOut        memory completion and read data
//   readHits, readMisses        saturating load hit/miss counters
module cache_controller #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int LINE_SIZE     = 32,
  parameter int SETS          = 16,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpuReqValid,
  output logic                     cpuReqReady,
  input  logic [ADDRESS_WIDTH-1:0] cpuReqAddress,
  input  logic [LINE_SIZE-1:0]     cpuReqDataIn,
  input  logic                     cpuReqWen,
  output logic                     cpuRespValid,
  output logic [LINE_SIZE-1:0]     cpuRespDataOut,
  output logic                     memReqValid,
  output logic [ADDRESS_WIDTH-1:0] memReqAddress,
  output logic [LINE_SIZE-1:0]     memReqDataIn,
  output logic                     memReqWen,
  input  logic                     memRespValid,
  input  logic [LINE_SIZE-1:0]     memRespDataOut,
  output logic [COUNT_WIDTH-1:0]   readHits,
  output logic [COUNT_WIDTH-1:0]   readMisses
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDRESS_WIDTH - 2 - IDX_W;

  typedef enum logic [1:0] {ST_IDLE, ST_LOOKUP, ST_MEM, ST_RESP} state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_SIZE-1:0]     wdata_q, wdata_d;
  logic                     wen_q, wen_d;
  logic [SETS-1:0]          valid_q, valid_d;
  logic                     mem_req_valid_q, mem_req_valid_d;
  logic [ADDRESS_WIDTH-1:0] mem_req_addr_q, mem_req_addr_d;
  logic [LINE_SIZE-1:0]     mem_req_data_q, mem_req_data_d;
  logic                     mem_req_wen_q, mem_req_wen_d;
  logic                     cpu_resp_valid_q, cpu_resp_valid_d;
  logic [LINE_SIZE-1:0]     cpu_resp_data_q, cpu_resp_data_d;
  logic [COUNT_WIDTH-1:0]   read_hits_q, read_hits_d;
  logic [COUNT_WIDTH-1:0]   read_misses_q, read_misses_d;

  // Tag and data arrays carry no reset; only the valid bits do.
  logic [TAG_W-1:0]         tag_q  [SETS];
  logic [LINE_SIZE-1:0]     data_q [SETS];

  logic [IDX_W-1:0]         req_idx;
  logic [TAG_W-1:0]         req_tag;
  logic                     hit;
  logic                     line_we;
  logic [LINE_SIZE-1:0]     line_wdata;

  assign req_idx = addr_q[2+IDX_W-1:2];
  assign req_tag = addr_q[ADDRESS_WIDTH-1:2+IDX_W];
  assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    wen_d            = wen_q;
    valid_d          = valid_q;
    mem_req_valid_d  = mem_req_valid_q;
    mem_req_addr_d   = mem_req_addr_q;
    mem_req_data_d   = mem_req_data_q;
    mem_req_wen_d    = mem_req_wen_q;
    cpu_resp_valid_d = 1'b0;
    cpu_resp_data_d  = cpu_resp_data_q;
    read_hits_d      = read_hits_q;
    read_misses_d    = read_misses_q;
    line_we          = 1'b0;
    line_wdata       = wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cpuReqValid) begin
          addr_d  = cpuReqAddress;
          wdata_d = cpuReqDataIn;
          wen_d   = cpuReqWen;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (!wen_q && hit) begin
          cpu_resp_valid_d = 1'b1;
          cpu_resp_data_d  = data_q[req_idx];
          if (!(&read_hits_q)) read_hits_d = read_hits_q + COUNT_WIDTH'(1);
          state_d = ST_RESP;
        end else begin
          mem_req_valid_d = 1'b1;
          mem_req_addr_d  = addr_q;
          mem_req_data_d  = wdata_q;
          mem_req_wen_d   = wen_q;
          if (!wen_q && !(&read_misses_q)) read_misses_d = read_misses_q + COUNT_WIDTH'(1);
          // Store hit refreshes the line now; a store miss never allocates.
          if (wen_q && hit) line_we = 1'b1;
          state_d = ST_MEM;
        end
      end
      ST_MEM: begin
        // memReqValid stays high through the cycle memRespValid is sampled.
        if (memRespValid) begin
          mem_req_valid_d  = 1'b0;
          cpu_resp_valid_d = 1'b1;
          cpu_resp_data_d  = wen_q ? wdata_q : memRespDataOut;
          if (!wen_q) begin
            line_we          = 1'b1;
            line_wdata       = memRespDataOut;
            valid_d[req_idx] = 1'b1;
          end
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= ST_IDLE;
      addr_q           <= '0;
      wdata_q          <= '0;
      wen_q            <= 1'b0;
      valid_q          <= '0;
      mem_req_valid_q  <= 1'b0;
      mem_req_addr_q   <= '0;
      mem_req_data_q   <= '0;
      mem_req_wen_q    <= 1'b0;
      cpu_resp_valid_q <= 1'b0;
      cpu_resp_data_q  <= '0;
      read_hits_q      <= '0;
      read_misses_q    <= '0;
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      wdata_q          <= wdata_d;
      wen_q            <= wen_d;
      valid_q          <= valid_d;
      mem_req_valid_q  <= mem_req_valid_d;
      mem_req_addr_q   <= mem_req_addr_d;
      mem_req_data_q   <= mem_req_data_d;
      mem_req_wen_q    <= mem_req_wen_d;
      cpu_resp_valid_q <= cpu_resp_valid_d;
      cpu_resp_data_q  <= cpu_resp_data_d;
      read_hits_q      <= read_hits_d;
      read_misses_q    <= read_misses_d;
    end
  end

  // line_we is only raised outside reset (state is forced to IDLE there).
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[req_idx]  <= req_tag;
      data_q[req_idx] <= line_wdata;
    end
  end

  assign cpuReqReady    = (state_q == ST_IDLE) && rst;
  assign cpuRespValid   = cpu_resp_valid_q;
  assign cpuRespDataOut = cpu_resp_data_q;
  assign memReqValid    = mem_req_valid_q;
  assign memReqAddress  = mem_req_addr_q;
  assign memReqDataIn   = mem_req_data_q;
  assign memReqWen      = mem_req_wen_q;
  assign readHits       = read_hits_q;
  assign readMisses     = read_misses_q;

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - self-checking bench for cache_controller with a DELAY=4 memory
//
// Purpose: drives directed and random CPU loads/stores, models main memory,
// and compares responses, latency, memory requests and counters with a
// reference model of the cache rules.
// Ports: none (top-level bench).
module tb_cache_controller;

  localparam int AW    = 32;
  localparam int LW    = 32;
  localparam int SETS  = 16;
  localparam int CW    = 4;
  localparam int DELAY = 4;
  localparam logic [CW-1:0] CMAX = '1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cpuReqValid = 1'b0;
  logic          cpuReqReady;
  logic [AW-1:0] cpuReqAddress = '0;
  logic [LW-1:0] cpuReqDataIn = '0;
  logic          cpuReqWen = 1'b0;
  logic          cpuRespValid;
  logic [LW-1:0] cpuRespDataOut;
  logic          memReqValid;
  logic [AW-1:0] memReqAddress;
  logic [LW-1:0] memReqDataIn;
  logic          memReqWen;
  logic          memRespValid;
  logic [LW-1:0] memRespDataOut;
  logic [CW-1:0] readHits;
  logic [CW-1:0] readMisses;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cache_controller #(
    .ADDRESS_WIDTH(AW), .LINE_SIZE(LW), .SETS(SETS), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .cpuReqValid(cpuReqValid), .cpuReqReady(cpuReqReady),
    .cpuReqAddress(cpuReqAddress), .cpuReqDataIn(cpuReqDataIn), .cpuReqWen(cpuReqWen),
    .cpuRespValid(cpuRespValid), .cpuRespDataOut(cpuRespDataOut),
    .memReqValid(memReqValid), .memReqAddress(memReqAddress),
    .memReqDataIn(memReqDataIn), .memReqWen(memReqWen),
    .memRespValid(memRespValid), .memRespDataOut(memRespDataOut),
    .readHits(readHits), .readMisses(readMisses)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Main memory: sees a request, raises its response DELAY-1 edges later,
  // and clears it on the edge where memReqValid is still high.
  logic [LW-1:0] mem_store [int unsigned];
  logic mem_busy, mem_wait_low;
  int   mem_cnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      memRespValid   <= 1'b0;
      memRespDataOut <= '0;
      mem_busy       <= 1'b0;
      mem_wait_low   <= 1'b0;
      mem_cnt        <= 0;
    end else begin
      if (memRespValid && memReqValid) begin
        memRespValid <= 1'b0;
        mem_busy     <= 1'b0;
        mem_wait_low <= 1'b1;
      end else if (mem_busy && !memRespValid) begin
        if (mem_cnt == DELAY - 1) begin
          memRespValid <= 1'b1;
          if (memReqWen) mem_store[memReqAddress[AW-1:2]] = memReqDataIn;
          else memRespDataOut <= mem_store.exists(memReqAddress[AW-1:2]) ?
                                 mem_store[memReqAddress[AW-1:2]] : '0;
        end else begin
          mem_cnt <= mem_cnt + 1;
        end
      end else if (!mem_busy && memReqValid && !mem_wait_low) begin
        mem_busy <= 1'b1;
        mem_cnt  <= 1;
      end
      if (!memReqValid) mem_wait_low <= 1'b0;
    end
  end

  // Spacing between memory transactions and single-cycle response pulses.
  logic prev_mreq = 1'b0, prev_resp = 1'b0, seen_mreq = 1'b0;
  int   low_run = 0;
  always @(negedge clk) begin
    if (memReqValid && !prev_mreq && seen_mreq) check("mem_gap>=2", 64'(low_run >= 2), 64'd1);
    if (cpuRespValid) check("resp_one_cycle", 64'(prev_resp), 64'd0);
    if (memReqValid) begin low_run = 0; seen_mreq = 1'b1; end
    else low_run++;
    prev_mreq = memReqValid;
    prev_resp = cpuRespValid;
  end

  // Reference model: cache as valid/tag/data per set over an ideal memory.
  bit            ref_valid [SETS];
  int unsigned   ref_tag   [SETS];
  logic [LW-1:0] ref_data  [SETS];
  logic [LW-1:0] ref_mem   [int unsigned];
  int            ref_hits = 0, ref_misses = 0;

  task automatic model_reset();
    for (int i = 0; i < SETS; i++) ref_valid[i] = 1'b0;
    ref_hits = 0;
    ref_misses = 0;
  endtask

  task automatic do_req(input logic [AW-1:0] a, input logic w, input logic [LW-1:0] d,
                        input bit hold, output bit was_hit);
    int unsigned   word, idx, tg;
    logic [LW-1:0] exp_data;
    bit            hitm, acc, got, saw_mem;
    int            k;
    word = a >> 2;
    idx  = word % SETS;
    tg   = word / SETS;
    hitm = ref_valid[idx] && (ref_tag[idx] == tg);
    if (w) begin
      ref_mem[word] = d;
      if (hitm) ref_data[idx] = d;
      exp_data = d;
    end else if (hitm) begin
      exp_data = ref_data[idx];
      if (ref_hits < int'(CMAX)) ref_hits++;
    end else begin
      exp_data = ref_mem.exists(word) ? ref_mem[word] : '0;
      if (ref_misses < int'(CMAX)) ref_misses++;
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = tg;
      ref_data[idx]  = exp_data;
    end
    was_hit = hitm && !w;

    @(negedge clk);
    cpuReqValid   = 1'b1;
    cpuReqAddress = a;
    cpuReqDataIn  = d;
    cpuReqWen     = w;
    acc = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (cpuReqReady) begin acc = 1'b1; break; end
      @(negedge clk);
    end
    if (!acc) begin
      check("accept_timeout", 64'd0, 64'd1);
      cpuReqValid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (!hold) cpuReqValid = 1'b0;

    got = 1'b0;
    saw_mem = 1'b0;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (memReqValid && !saw_mem) begin
        saw_mem = 1'b1;
        check("mem_addr", 64'(memReqAddress), 64'(a));
        check("mem_wen", 64'(memReqWen), 64'(w));
        if (w) check("mem_wdata", 64'(memReqDataIn), 64'(d));
      end
      if (cpuRespValid) begin got = 1'b1; break; end
    end
    if (!got) begin
      check("resp_timeout", 64'd0, 64'd1);
      return;
    end
    check("resp_data", 64'(cpuRespDataOut), 64'(exp_data));
    check("latency", 64'(k - 1), was_hit ? 64'd1 : 64'(DELAY + 2));
    check("mem_used", 64'(saw_mem), was_hit ? 64'd0 : 64'd1);
    check("read_hits", 64'(readHits), 64'(ref_hits));
    check("read_misses", 64'(readMisses), 64'(ref_misses));
  endtask

  initial begin : stim
    bit h;
    int resp_seen;
    logic [AW-1:0] ra;

    // Reset with a request present: it must be ignored.
    model_reset();
    cpuReqValid   = 1'b1;
    cpuReqAddress = 32'h40;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(cpuReqReady), 64'd0);
    check("rst_mreq", 64'(memReqValid), 64'd0);
    check("rst_resp", 64'(cpuRespValid), 64'd0);
    check("rst_resp_data", 64'(cpuRespDataOut), 64'd0);
    check("rst_mem_addr", 64'(memReqAddress), 64'd0);
    check("rst_mem_data", 64'(memReqDataIn), 64'd0);
    check("rst_mem_wen", 64'(memReqWen), 64'd0);
    check("rst_hits", 64'(readHits), 64'd0);
    check("rst_misses", 64'(readMisses), 64'd0);
    cpuReqValid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("idle_ready", 64'(cpuReqReady), 64'd1);

    // Cold miss, hit, write-through store hit and readback.
    do_req(32'h40, 1'b0, 32'h0, 1'b0, h);
    check("t1_miss", 64'(h), 64'd0);
    do_req(32'h40, 1'b0, 32'h5555, 1'b0, h);
    check("t2_hit", 64'(h), 64'd1);
    do_req(32'h40, 1'b1, 32'hDEADBEEF, 1'b0, h);
    do_req(32'h40, 1'b0, 32'h0, 1'b0, h);
    check("t3_hit", 64'(h), 64'd1);

    // Store miss does not allocate; 0x40 and 0x80 conflict in set 0.
    do_req(32'h80, 1'b1, 32'h12345678, 1'b0, h);
    do_req(32'h80, 1'b0, 32'h0, 1'b0, h);
    check("t4_80_miss", 64'(h), 64'd0);
    do_req(32'h40, 1'b0, 32'h0, 1'b0, h);
    check("t4_40_miss", 64'(h), 64'd0);

    // Back-to-back with cpuReqValid held: second is taken only after RESP.
    do_req(32'h100, 1'b0, 32'h0, 1'b1, h);
    check("t5_ready_in_resp", 64'(cpuReqReady), 64'd0);
    do_req(32'h100, 1'b0, 32'h0, 1'b0, h);
    check("t5_second_hit", 64'(h), 64'd1);

    // Reset in the middle of a load miss.
    @(negedge clk);
    cpuReqValid   = 1'b1;
    cpuReqAddress = 32'h200;
    cpuReqWen     = 1'b0;
    for (int i = 0; i < 20 && !cpuReqReady; i++) @(negedge clk);
    @(posedge clk);
    #1 cpuReqValid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("t6_mreq_drop", 64'(memReqValid), 64'd0);
    check("t6_hits_clr", 64'(readHits), 64'd0);
    check("t6_misses_clr", 64'(readMisses), 64'd0);
    model_reset();
    resp_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (cpuRespValid) resp_seen++;
    end
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (cpuRespValid) resp_seen++;
    end
    check("t6_no_resp", 64'(resp_seen), 64'd0);
    do_req(32'h40, 1'b0, 32'h0, 1'b0, h);
    check("t6_40_miss", 64'(h), 64'd0);
    do_req(32'h200, 1'b0, 32'h0, 1'b0, h);
    check("t6_200_miss", 64'(h), 64'd0);

    // Random traffic over a small tag pool; counters saturate at CW bits.
    for (int n = 0; n < 200; n++) begin
      ra = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, SETS - 1)),
            2'($urandom_range(0, 3))};
      do_req(ra, ($urandom_range(0, 9) < 3), $urandom, 1'b0, h);
    end
    check("sat_hits", 64'(readHits), 64'(CMAX));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
